// File: rtl/mux_arb_pkg.sv
// Shared state encoding and rotating-priority search for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_GRANT   = GRANT,
        ST_RELEASE = RELEASE
    } arb_state_e;

    // Upper bound on channel count the search function handles.
    localparam int MAX_CH = 64;
    localparam int IDX_W  = 6;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of req searching ptr, ptr+1, ... modulo channels.
    function automatic pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                      input int ptr,
                                      input int channels);
        pick_t res;
        int    c;
        res.found = 1'b0;
        res.idx   = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i < channels) begin
                c = ptr + i;
                if (c >= channels) begin
                    c = c - channels;
                end
                if (!res.found && req[c]) begin
                    res.found = 1'b1;
                    res.idx   = c[IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/data bundle between requesters and the arbiter's shared output.
interface mux_rr_arbiter_if #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 1
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0]       req;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       gnt;
    logic [SEL_W-1:0]          sel;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic                      busy;

    modport master (
        output req, in_data,
        input  gnt, sel, out_valid, out_data, busy
    );

    modport slave (
        input  req, in_data,
        output gnt, sel, out_valid, out_data, busy
    );
endinterface

// File: rtl/mux.sv
// Parameterized N:1 mux; out-of-range select yields zero.
module mux #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 1,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data
);

    // Select the channel slice addressed by sel.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) begin
                out_data = in_data[i*WIDTH +: WIDTH];
            end else begin
                out_data = out_data;
            end
        end
    end

endmodule

// File: rtl/top_mux_arb_fpga.sv
// Board wrapper: switches supply requests and data, green LEDs show grant and output.
module top_mux_arb_fpga (
    input  logic        CLOCK_50,
    input  logic [17:0] SW,
    input  logic [3:0]  KEY,
    output logic [7:0]  LEDG
);

    logic unused_s;

    mux_rr_arbiter_if #(.CHANNELS(8), .WIDTH(1)) arb_if ();

    assign arb_if.req     = SW[7:0];
    assign arb_if.in_data = SW[17:10];

    mux_rr_arbiter #(
        .CHANNELS (8),
        .WIDTH    (1),
        .MAX_HOLD (16)
    ) u_arb (
        .clk (CLOCK_50),
        .rst (~KEY[0]),
        .bus (arb_if.slave)
    );

    assign LEDG     = {arb_if.gnt[7:1], arb_if.out_data};
    assign unused_s = ^{SW[9:8], KEY[3:1], arb_if.gnt[0], arb_if.sel,
                        arb_if.out_valid, arb_if.busy};

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the shared mux select, with bounded hold and a
// one-cycle dead gap between grants.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_arbiter_if.slave   bus
);

    localparam int SEL_W  = $clog2(CHANNELS);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    arb_state_e          state_q, state_d;
    logic [CHANNELS-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                valid_q;
    logic                busy_q;

    logic [SEL_W-1:0]    search_ptr_s;
    pick_t               pick_s;
    logic                hold_last_s;
    logic                others_s;
    logic [WIDTH-1:0]    mux_out_s;

    assign hold_last_s = (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign others_s    = |(bus.req & ~gnt_q);

    // In RELEASE the search starts just past the outgoing owner, which is also the new ptr.
    always_comb begin
        search_ptr_s = ptr_q;
        if (state_q == ST_RELEASE) begin
            if (sel_q == SEL_W'(CHANNELS - 1)) begin
                search_ptr_s = '0;
            end else begin
                search_ptr_s = sel_q + SEL_W'(1);
            end
        end else begin
            search_ptr_s = ptr_q;
        end
    end

    assign pick_s = rr_pick(MAX_CH'(bus.req), int'(search_ptr_s), CHANNELS);

    // Next-state, grant, pointer and hold-counter logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                ptr_d = search_ptr_s;
                gnt_d = '0;
                if (pick_s.found) begin
                    state_d                       = ST_GRANT;
                    gnt_d[pick_s.idx[SEL_W-1:0]]  = 1'b1;
                    sel_d                         = pick_s.idx[SEL_W-1:0];
                    hold_d                        = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (hold_last_s) begin
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                // Owner drop and preemption share the same exit.
                if (!bus.req[sel_q] || (hold_last_s && others_s)) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                sel_d   = '0;
                ptr_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            valid_q <= (state_d == ST_GRANT);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    mux #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_mux (
        .in_data  (bus.in_data),
        .sel      (sel_q),
        .out_data (mux_out_s)
    );

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_data  = mux_out_s & {WIDTH{valid_q}};

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench: directed vector table, hand sequences, and random traffic
// checked against a queue-free behavioural round-robin model.
module tb_mux_rr_arbiter;

    localparam int CH   = 8;
    localparam int HOLD = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mux_rr_arbiter_if #(.CHANNELS(CH), .WIDTH(1)) bus ();

    mux_rr_arbiter #(
        .CHANNELS (CH),
        .WIDTH    (1),
        .MAX_HOLD (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] din;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       data;
        logic       busy;
    } vec_t;

    vec_t vecs [16];

    // Behavioural model: current owner (-1 none), pending dead cycle, search start, run length.
    int         m_owner;
    int         m_ptr;
    int         m_sel;
    int         m_run;
    bit         m_rel;
    logic [7:0] m_din;

    task automatic model_step(input bit r, input logic [7:0] rq);
        bit done;
        int c;
        if (r) begin
            m_owner = -1; m_rel = 1'b0; m_ptr = 0; m_sel = 0; m_run = 0;
        end else if (m_owner >= 0) begin
            m_run = m_run + 1;
            if (!rq[m_owner] ||
                ((m_run % HOLD) == 0 && (rq & ~(8'd1 << m_owner)) != 8'd0)) begin
                m_ptr   = (m_owner + 1) % CH;
                m_owner = -1;
                m_rel   = 1'b1;
            end
        end else begin
            m_rel = 1'b0;
            done  = 1'b0;
            for (int k = 0; k < CH; k++) begin
                c = (m_ptr + k) % CH;
                if (!done && rq[c]) begin
                    done = 1'b1; m_owner = c; m_sel = c; m_run = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input logic [7:0] rq, input logic [7:0] din);
        rst         = r;
        bus.req     = rq;
        bus.in_data = din;
        m_din       = din;
        @(posedge clk);
        model_step(r, rq);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eg;
        eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        check({tag, ".gnt"},   bus.gnt, eg);
        check({tag, ".sel"},   bus.sel, m_sel);
        check({tag, ".valid"}, bus.out_valid, m_owner >= 0);
        check({tag, ".data"},  bus.out_data, (m_owner >= 0) ? m_din[m_sel] : 1'b0);
        check({tag, ".busy"},  bus.busy, (m_owner >= 0) || m_rel);
        check({tag, ".onehot"}, $countones(bus.gnt) <= 1, 1);
        check({tag, ".gnt_iff_valid"}, |bus.gnt, bus.out_valid);
    endtask

    task automatic check_grant(input string tag, input int ch, input logic [7:0] din);
        check({tag, ".gnt"},   bus.gnt, 8'd1 << ch);
        check({tag, ".sel"},   bus.sel, ch);
        check({tag, ".valid"}, bus.out_valid, 1);
        check({tag, ".data"},  bus.out_data, din[ch]);
    endtask

    task automatic check_gap(input string tag);
        check({tag, ".gnt"},   bus.gnt, 0);
        check({tag, ".valid"}, bus.out_valid, 0);
        check({tag, ".busy"},  bus.busy, 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".gnt"},   bus.gnt, 0);
        check({tag, ".sel"},   bus.sel, 0);
        check({tag, ".valid"}, bus.out_valid, 0);
        check({tag, ".data"},  bus.out_data, 0);
        check({tag, ".busy"},  bus.busy, 0);
    endtask

    initial begin
        logic [7:0] rq;
        logic [7:0] din;
        bit         r;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; bus.req = 8'h00; bus.in_data = 8'h00;
        m_owner = -1; m_rel = 1'b0; m_ptr = 0; m_sel = 0; m_run = 0; m_din = 8'h00;

        //           rst   req    din    gnt    sel   valid data  busy
        vecs[0]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 8'h20, 8'h00, 3'd5, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 8'h20, 8'h00, 3'd5, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h21, 8'h21, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 8'h21, 8'h20, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 8'h20, 8'h20, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 8'h20, 8'h20, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].rst, vecs[i].req, vecs[i].din);
            check($sformatf("vec%0d.gnt", i),   bus.gnt,       vecs[i].gnt);
            check($sformatf("vec%0d.sel", i),   bus.sel,       vecs[i].sel);
            check($sformatf("vec%0d.valid", i), bus.out_valid, vecs[i].valid);
            check($sformatf("vec%0d.data", i),  bus.out_data,  vecs[i].data);
            check($sformatf("vec%0d.busy", i),  bus.busy,      vecs[i].busy);
        end

        // Full contention: every channel gets HOLD cycles, one dead cycle between, then wrap to ch0.
        cycle(1'b1, 8'hFF, 8'hA5);
        check_reset("contend.rst");
        for (int g = 0; g <= CH; g++) begin
            for (int k = 0; k < HOLD; k++) begin
                cycle(1'b0, 8'hFF, 8'hA5);
                check_grant($sformatf("contend.ch%0d.c%0d", g % CH, k), g % CH, 8'hA5);
            end
            if (g < CH) begin
                cycle(1'b0, 8'hFF, 8'hA5);
                check_gap($sformatf("contend.gap%0d", g));
            end
        end

        // Lone requester keeps the grant across hold-counter wraps.
        cycle(1'b1, 8'h00, 8'h20);
        check_reset("solo.rst");
        for (int k = 0; k < 40; k++) begin
            cycle(1'b0, 8'h20, 8'h20);
            check_grant($sformatf("solo.c%0d", k), 5, 8'h20);
        end

        // Reset during the second cycle of a ch3 grant, then search restarts from 0.
        cycle(1'b1, 8'h00, 8'h88);
        cycle(1'b0, 8'h88, 8'h88);
        check_grant("midrst.c1", 3, 8'h88);
        cycle(1'b0, 8'h88, 8'h88);
        check_grant("midrst.c2", 3, 8'h88);
        cycle(1'b1, 8'h88, 8'h88);
        check_reset("midrst.rst");
        for (int k = 0; k < HOLD; k++) begin
            cycle(1'b0, 8'h88, 8'h88);
            check_grant($sformatf("midrst.regrant%0d", k), 3, 8'h88);
        end
        cycle(1'b0, 8'h88, 8'h88);
        check_gap("midrst.gap");
        cycle(1'b0, 8'h88, 8'h88);
        check_grant("midrst.ch7", 7, 8'h88);

        // Random traffic against the model; requests tend to persist to exercise holds.
        rq = 8'h00;
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) begin
                rq = 8'($urandom) & 8'($urandom);
            end
            din = 8'($urandom);
            cycle(r, rq, din);
            check_model($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
